// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding and default geometry for the serial bit loader
package loader_pkg;
  typedef enum logic {EMPTY, FULL} loader_state_t;
  localparam int LOADER_WORD_W   = 16;
  localparam int LOADER_DEBOUNCE = 4;
  localparam int LOADER_SYNC     = 2;
endpackage

// File: rtl/sync_debounce.sv
// sync_debounce: pin synchronizer with debounced level and a registered rising-edge pulse
module sync_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic pin,
  output logic rdy_db,
  output logic rise
);
  localparam int DW = $clog2(DEBOUNCE + 1);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic db_q, db_d, rise_q, rise_d, lvl, settled;
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], pin};
    lvl     = sync_q[SYNC_STAGES-1];
    settled = cnt_q == DW'(DEBOUNCE - 1);
    db_d    = (lvl != db_q && settled) ? lvl : db_q;
    cnt_d   = (lvl == db_q || settled) ? '0 : cnt_q + DW'(1);
    rise_d  = db_d & ~db_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
      cnt_q  <= '0;
      db_q   <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      db_q   <= db_d;
      rise_q <= rise_d;
    end
  end
  assign rdy_db = db_q;
  assign rise   = rise_q;
endmodule

// File: rtl/serial_bit_loader.sv
// serial_bit_loader: assembles debounced serial pin bits into words with a valid/ack handshake
module serial_bit_loader
  import loader_pkg::*;
#(
  parameter int WORD_W      = LOADER_WORD_W,
  parameter int SYNC_STAGES = LOADER_SYNC,
  parameter int DEBOUNCE    = LOADER_DEBOUNCE
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_bit,
  input  logic                      ready,
  input  logic                      word_ack,
  output logic [WORD_W-1:0]         word_out,
  output logic                      word_valid,
  output logic [$clog2(WORD_W)-1:0] bit_count,
  output logic                      overrun
);
  localparam int CW = $clog2(WORD_W);
  logic [SYNC_STAGES-1:0] bit_sync_q, bit_sync_d;
  logic [WORD_W-1:0] sr_q, sr_d, word_q, word_d, next_word;
  logic [CW-1:0] cnt_q, cnt_d;
  loader_state_t state_q, state_d;
  logic ovr_q, ovr_d, rdy_db, rise, sample, complete;
  sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE(DEBOUNCE)) u_rdy (
    .clock  (clock),
    .reset  (reset),
    .pin    (ready),
    .rdy_db (rdy_db),
    .rise   (rise)
  );
  // in_bit takes the same synchronizer depth so it lines up with the ready path
  always_comb begin
    bit_sync_d = {bit_sync_q[SYNC_STAGES-2:0], in_bit};
    sample     = rise & rdy_db;
    next_word  = {sr_q[WORD_W-2:0], bit_sync_q[SYNC_STAGES-1]};
    complete   = sample && cnt_q == CW'(WORD_W - 1);
    sr_d       = sample ? next_word : sr_q;
    cnt_d      = complete ? '0 : sample ? cnt_q + CW'(1) : cnt_q;
    state_d    = state_q == EMPTY ? (complete ? FULL : EMPTY)
                                  : ((complete || !word_ack) ? FULL : EMPTY);
    word_d     = (complete && (state_q == EMPTY || word_ack)) ? next_word : word_q;
    ovr_d      = ovr_q | (complete && state_q == FULL && !word_ack);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      bit_sync_q <= '0;
      sr_q       <= '0;
      word_q     <= '0;
      cnt_q      <= '0;
      state_q    <= EMPTY;
      ovr_q      <= 1'b0;
    end else begin
      bit_sync_q <= bit_sync_d;
      sr_q       <= sr_d;
      word_q     <= word_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      ovr_q      <= ovr_d;
    end
  end
  assign word_out   = word_q;
  assign word_valid = state_q == FULL;
  assign bit_count  = cnt_q;
  assign overrun    = ovr_q;
endmodule

// File: tb/tb_serial_bit_loader.sv
// tb_serial_bit_loader: vector table, corner sequences and a queue-based random reference model
module tb_serial_bit_loader;
  logic clock = 1'b0;
  logic reset = 1'b1, in_bit = 1'b0, ready = 1'b0, word_ack = 1'b0;
  logic [15:0] word_out;
  logic word_valid, overrun;
  logic [3:0] bit_count;
  int total = 0, bad = 0;

  typedef struct {
    logic [15:0] word;
    bit          ack;
    logic        exp_v;
    logic [15:0] exp_w;
    logic        exp_o;
  } vec_t;
  vec_t tbl [5];

  always #5 clock = ~clock;

  serial_bit_loader #(.WORD_W(16), .SYNC_STAGES(2), .DEBOUNCE(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_bit     (in_bit),
    .ready      (ready),
    .word_ack   (word_ack),
    .word_out   (word_out),
    .word_valid (word_valid),
    .bit_count  (bit_count),
    .overrun    (overrun)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  // ready rise at N0; word_valid sampled at N6 (before any ack) and N7
  task automatic strobe_ex(input logic b, input logic ack, output logic v6, output logic v7);
    tick(4);
    in_bit = b;
    tick(4);
    ready = 1'b1;
    tick(6);
    v6 = word_valid;
    word_ack = ack;
    tick(1);
    v7 = word_valid;
    word_ack = 1'b0;
    tick(1);
    ready = 1'b0;
  endtask

  task automatic strobe(input logic b);
    logic a, c;
    strobe_ex(b, 1'b0, a, c);
  endtask

  task automatic shift_bits(input logic [15:0] w, input int n);
    for (int i = 15; i > 15 - n; i--) strobe(w[i]);
  endtask

  task automatic pulse_ack;
    word_ack = 1'b1;
    tick(1);
    word_ack = 1'b0;
  endtask

  initial begin
    logic v6, v7;
    logic q [$];
    logic mvalid, movr;
    logic [15:0] mword;

    tbl[0] = '{16'h1234, 1'b0, 1'b1, 16'h1234, 1'b0};
    tbl[1] = '{16'hBEEF, 1'b1, 1'b0, 16'h1234, 1'b1};
    tbl[2] = '{16'h0F0F, 1'b0, 1'b1, 16'h0F0F, 1'b1};
    tbl[3] = '{16'hFFFF, 1'b1, 1'b0, 16'h0F0F, 1'b1};
    tbl[4] = '{16'h0001, 1'b0, 1'b1, 16'h0001, 1'b1};

    tick(1);
    do_reset;
    chk("rst_word", word_out, 0);
    chk("rst_valid", word_valid, 0);
    chk("rst_count", bit_count, 0);
    chk("rst_ovr", overrun, 0);

    shift_bits(16'hA5C3, 15);
    chk("clean_count15", bit_count, 15);
    strobe_ex(1'b1, 1'b0, v6, v7);
    chk("clean_lat_early", v6, 0);
    chk("clean_lat_on", v7, 1);
    chk("clean_word", word_out, 16'hA5C3);
    chk("clean_count", bit_count, 0);

    do_reset;
    shift_bits(16'hFFFF, 3);
    ready = 1'b1;
    tick(3);
    ready = 1'b0;
    tick(12);
    chk("glitch_3", bit_count, 3);
    ready = 1'b1;
    tick(4);
    ready = 1'b0;
    tick(12);
    chk("glitch_4", bit_count, 4);

    do_reset;
    shift_bits(16'h1234, 16);
    chk("skid_pend_valid", word_valid, 1);
    chk("skid_pend_word", word_out, 16'h1234);
    shift_bits(16'hBEEF, 15);
    strobe_ex(1'b1, 1'b1, v6, v7);
    chk("skid_valid_evt", v6, 1);
    chk("skid_valid_after", v7, 1);
    chk("skid_word", word_out, 16'hBEEF);
    chk("skid_ovr", overrun, 0);

    do_reset;
    foreach (tbl[i]) begin
      shift_bits(tbl[i].word, 16);
      chk($sformatf("tbl%0d_count", i), bit_count, 0);
      if (tbl[i].ack) pulse_ack;
      tick(1);
      chk($sformatf("tbl%0d_valid", i), word_valid, tbl[i].exp_v);
      chk($sformatf("tbl%0d_word", i), word_out, tbl[i].exp_w);
      chk($sformatf("tbl%0d_ovr", i), overrun, tbl[i].exp_o);
    end

    do_reset;
    shift_bits(16'hFFFF, 5);
    chk("midrst_pre", bit_count, 5);
    do_reset;
    chk("midrst_count", bit_count, 0);
    chk("midrst_valid", word_valid, 0);
    shift_bits(16'h0F0F, 16);
    chk("midrst_word", word_out, 16'h0F0F);
    chk("midrst_valid2", word_valid, 1);
    chk("midrst_ovr", overrun, 0);

    do_reset;
    mvalid = 1'b0;
    movr = 1'b0;
    mword = '0;
    for (int n = 0; n < 200; n++) begin
      logic b;
      b = 1'($urandom_range(0, 1));
      strobe(b);
      q.push_back(b);
      if (q.size() == 16) begin
        if (!mvalid) begin
          mvalid = 1'b1;
          foreach (q[k]) mword[15-k] = q[k];
        end else movr = 1'b1;
        q.delete();
      end
      chk($sformatf("rnd%0d_count", n), bit_count, q.size());
      chk($sformatf("rnd%0d_valid", n), word_valid, mvalid);
      chk($sformatf("rnd%0d_word", n), word_out, mword);
      chk($sformatf("rnd%0d_ovr", n), overrun, movr);
      if ($urandom_range(0, 23) == 0) begin
        pulse_ack;
        mvalid = 1'b0;
        tick(1);
        chk($sformatf("rnd%0d_ack", n), word_valid, 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_bit_loader.md
# serial_bit_loader

Upstream input stage for the encryptor chip. Converts the slow, hand-driven serial pin pair (`in_bit` data, `ready` strobe) into complete, debounced words with a valid/ack handshake. Its output is consumed by the encryptor datapath inside `mychip_wrapper` in place of raw pin sampling. One clock domain; the pins are asynchronous and are synchronized here.

## Interface
- `WORD_W`, 16: bits per assembled word, ≥2.
- `SYNC_STAGES`, 2: flip-flop depth of the pin synchronizers, ≥2.
- `DEBOUNCE`, 4: consecutive cycles a synchronized `ready` level must hold before it is accepted, ≥1.

- `clock` in 1: sole clock.
- `reset` in 1: synchronous, active-high; clears all state.
- `in_bit` in 1: serial data pin, asynchronous.
- `ready` in 1: strobe pin, asynchronous; each accepted rising edge samples one bit.
- `word_out` out WORD_W: last completed word, MSB = first bit received.
- `word_valid` out 1: `word_out` holds an unconsumed word.
- `word_ack` in 1: consumer takes `word_out` this cycle when `word_valid`=1; ignored otherwise.
- `bit_count` out $clog2(WORD_W): bits held in the partial word (display aid).
- `overrun` out 1: sticky; a completed word was dropped.

## Operation
- `ready` and `in_bit` each pass through SYNC_STAGES flops.
- Debounce: a counter tracks how long the synchronized `ready` has differed from the accepted level `rdy_db`. When it differs for DEBOUNCE consecutive cycles, `rdy_db` takes the new level and the counter clears. Any cycle where the two agree also clears the counter.
- Sample event: a cycle where `rdy_db` goes 0→1. The synchronized `in_bit` in that same cycle is the sampled bit. Falling transitions are debounced but produce no event.
- Shift register `sr`: on a sample event, `sr <= {sr[WORD_W-2:0], bit}` and `bit_count` increments.
- Completion: a sample event with `bit_count == WORD_W-1` is a completing sample. On it, `bit_count` wraps to 0 and the completed word is `{sr[WORD_W-2:0], bit}`.
- FSM states:
  - EMPTY: `word_valid`=0. On completion, load `word_out` and go to FULL.
  - FULL: `word_valid`=1. Filling of `sr` continues, giving one word of skid.
    - `word_ack` without completion: go to EMPTY.
    - Completion with `word_ack` in the same cycle: load the new word and stay in FULL. `overrun` is unchanged.
    - Completion without `word_ack`: drop the new word, keep `word_out`, set `overrun`, stay in FULL.
- `word_ack` in EMPTY has no effect.
- `overrun` clears only on reset.

## Timing
- Reset values: `word_out`=0, `word_valid`=0, `bit_count`=0, `overrun`=0, FSM=EMPTY, `sr`=0, `rdy_db`=0, synchronizers=0, debounce counter=0.
- Reset mid-word or mid-handshake discards the partial word and any pending word. There is no output activity in the reset cycle.
- Latency from a clean `ready` rise at the pin to the sample event: SYNC_STAGES+DEBOUNCE cycles.
- `bit_count` and `sr` update on the clock edge ending the sample-event cycle.
- `word_valid`/`word_out` become visible the cycle after the completing sample event.
- `word_valid` falls the cycle after an accepted `word_ack`.
- Usage rule: `in_bit` must be stable from ≥SYNC_STAGES cycles before the `ready` pin rises until the sample event. Violations are not detected.
- Maximum accepted strobe rate: one event per 2·DEBOUNCE cycles.

## Structure
- Package `loader_pkg`:
  - `typedef enum logic {EMPTY, FULL} loader_state_t`
  - default constants `LOADER_WORD_W=16`, `LOADER_DEBOUNCE=4`, `LOADER_SYNC=2`
- Sub-module `sync_debounce`: synchronizer plus debounce counter. Parameters SYNC_STAGES and DEBOUNCE. Outputs the level `rdy_db` and a one-cycle pulse `rise`.
- `in_bit` uses a bare synchronizer of the same depth, so it stays aligned with `ready`.
- The FSM, shift register and counters live in `serial_bit_loader`.

## Test plan
All scenarios use WORD_W=16, DEBOUNCE=4, SYNC_STAGES=2. Pin strobes are 8 cycles high and 8 cycles low, with data set 4 cycles before each rise.

- Reset: after reset → `word_out`=0, `word_valid`=0, `bit_count`=0, `overrun`=0.
- Clean word: shift 0xA5C3 MSB-first → after the 16th rise, `word_valid`=1 exactly 2+4+1 cycles after the pin edge, `word_out`=16'hA5C3, `bit_count`=0.
- Glitch rejection: `ready` high for 3 cycles, then low → no sample, `bit_count` unchanged. `ready` held high 4 cycles → exactly one sample.
- Skid with same-cycle ack: word 0x1234 pending, then shift 0xBEEF and pulse `word_ack` in the completing event cycle → `word_out`=16'hBEEF, `word_valid` stays 1, `overrun`=0.
- Overrun: word 0x1234 unacked, then 0xBEEF completes → `word_out`=16'h1234, `overrun`=1. A later ack drops `word_valid`, and `overrun` remains 1.
- Reset mid-word: after 5 bits, pulse reset → `bit_count`=0. The next 16 bits 0x0F0F yield `word_out`=16'h0F0F with no stale bits.
